// File: rtl/nco_zc_freq_meter_if.sv
// Sample/result bus for the NCO zero-crossing frequency meter.
// master = sample source and result consumer, slave = meter.
interface nco_zc_freq_meter_if #(
    parameter int unsigned MPR       = 14,
    parameter int unsigned APR       = 30,
    parameter int unsigned LOG2_GATE = 10
);
    logic                 run;
    logic [MPR-1:0]       sample_i;
    logic                 sample_valid;
    logic                 result_ack_i;
    logic [APR-1:0]       phi_inc_est_o;
    logic [LOG2_GATE:0]   zc_count_o;
    logic [LOG2_GATE-1:0] span_o;
    logic                 result_valid_o;
    logic                 overrun_o;
    logic                 busy_o;

    modport master (
        output run, sample_i, sample_valid, result_ack_i,
        input  phi_inc_est_o, zc_count_o, span_o, result_valid_o, overrun_o, busy_o
    );

    modport slave (
        input  run, sample_i, sample_valid, result_ack_i,
        output phi_inc_est_o, zc_count_o, span_o, result_valid_o, overrun_o, busy_o
    );
endinterface

// File: rtl/nco_zc_freq_meter.sv
// Counts hysteretic rising zero crossings over 2^LOG2_GATE samples and reports a phase-increment estimate.
// Optional macro NCO_ZCFM_SPAN_EN adds first/last crossing tracking and span_o.
module nco_zc_freq_meter #(
    parameter int unsigned MPR       = 14,
    parameter int unsigned APR       = 30,
    parameter int unsigned LOG2_GATE = 10,
    parameter int unsigned HYST      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    nco_zc_freq_meter_if.slave    bus
);
    localparam int unsigned CW    = LOG2_GATE + 1;
    localparam int unsigned SHIFT = APR - LOG2_GATE;
    localparam logic [LOG2_GATE-1:0]  IDX_LAST = '1;
    localparam logic signed [MPR-1:0] HYST_P   = MPR'(HYST);
    localparam logic signed [MPR-1:0] HYST_N   = -HYST_P;

    typedef enum logic {ST_IDLE, ST_MEASURE} state_e;

    state_e               state_q, state_d;
    logic [LOG2_GATE-1:0] idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 arm_q, arm_d;
    logic [APR-1:0]       phi_q, phi_d;
    logic [CW-1:0]        zc_q, zc_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;

    logic signed [MPR-1:0] samp_c;
    logic                  xing_c;
    logic                  load_c;
    logic [CW-1:0]         cnt_nx_c;

`ifdef NCO_ZCFM_SPAN_EN
    logic [LOG2_GATE-1:0] first_q, first_d, last_q, last_d, span_q, span_d;
    logic [LOG2_GATE-1:0] first_nx_c, last_nx_c;
`endif

    assign samp_c = $signed(bus.sample_i);

    // Next-state, crossing detection, window close and result handshake
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        arm_d    = arm_q;
        phi_d    = phi_q;
        zc_d     = zc_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        xing_c   = 1'b0;
        load_c   = 1'b0;
        cnt_nx_c = cnt_q;
`ifdef NCO_ZCFM_SPAN_EN
        first_d    = first_q;
        last_d     = last_q;
        span_d     = span_q;
        first_nx_c = first_q;
        last_nx_c  = last_q;
`endif
        if (clken) begin
            if (!bus.run) begin
                ovr_d = 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.run) begin
                        state_d = ST_MEASURE;
                        idx_d   = '0;
                        cnt_d   = '0;
                        arm_d   = 1'b0;
`ifdef NCO_ZCFM_SPAN_EN
                        first_d = '0;
                        last_d  = '0;
`endif
                    end
                end
                ST_MEASURE: begin
                    if (!bus.run) begin
                        state_d = ST_IDLE;
                    end else if (bus.sample_valid) begin
                        xing_c = arm_q && (samp_c >= HYST_P);
                        if (samp_c <= HYST_N) begin
                            arm_d = 1'b1;
                        end else if (xing_c) begin
                            arm_d = 1'b0;
                        end
                        cnt_nx_c = cnt_q + CW'(xing_c);
`ifdef NCO_ZCFM_SPAN_EN
                        if (xing_c && (cnt_q == '0)) begin
                            first_nx_c = idx_q;
                        end
                        if (xing_c) begin
                            last_nx_c = idx_q;
                        end
`endif
                        idx_d = idx_q + 1'b1;
                        // Window end: this sample's own crossing is part of the result
                        if (idx_q == IDX_LAST) begin
                            load_c = 1'b1;
                            zc_d   = cnt_nx_c;
                            phi_d  = APR'(cnt_nx_c) << SHIFT;
                            cnt_d  = '0;
`ifdef NCO_ZCFM_SPAN_EN
                            span_d  = (cnt_nx_c < CW'(2)) ? '0 : (last_nx_c - first_nx_c);
                            first_d = '0;
                            last_d  = '0;
`endif
                        end else begin
                            cnt_d = cnt_nx_c;
`ifdef NCO_ZCFM_SPAN_EN
                            first_d = first_nx_c;
                            last_d  = last_nx_c;
`endif
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (load_c) begin
                valid_d = 1'b1;
                if (valid_q && !bus.result_ack_i) begin
                    ovr_d = 1'b1;
                end
            end else if (bus.result_ack_i) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
            phi_q   <= '0;
            zc_q    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
            phi_q   <= phi_d;
            zc_q    <= zc_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef NCO_ZCFM_SPAN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q <= '0;
            last_q  <= '0;
            span_q  <= '0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
            span_q  <= span_d;
        end
    end

    assign bus.span_o = span_q;
`else
    assign bus.span_o = '0;
`endif

    assign bus.phi_inc_est_o  = phi_q;
    assign bus.zc_count_o     = zc_q;
    assign bus.result_valid_o = valid_q;
    assign bus.overrun_o      = ovr_q;
    assign bus.busy_o         = (state_q == ST_MEASURE);
endmodule

// File: tb/tb_nco_zc_freq_meter.sv
// Scoreboard bench for nco_zc_freq_meter: stimulus pushes expected results, a monitor checks each new result.
module tb_nco_zc_freq_meter;
    localparam int unsigned MPR = 14, APR = 30, LG = 10;
`ifdef NCO_ZCFM_SPAN_EN
    localparam int SPAN_P = 1016;
`else
    localparam int SPAN_P = 0;
`endif

    typedef struct {
        logic [LG:0]    zc;
        logic [APR-1:0] phi;
        logic [LG-1:0]  span;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic clken;
    bit   auto_ack = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t exp_p, exp_z;
    int   ncyc;

    nco_zc_freq_meter_if #(.MPR(MPR), .APR(APR), .LOG2_GATE(LG)) bus ();

    nco_zc_freq_meter #(.MPR(MPR), .APR(APR), .LOG2_GATE(LG), .HYST(64)) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [MPR-1:0] wave(input int kind, input int k);
        if (kind == 0) return ((k % 8) < 4) ? MPR'(-1000) : MPR'(1000);
        return ((k % 2) == 0) ? MPR'(50) : MPR'(-50);
    endfunction

    // Feeds n accepted samples; returns cycles used. Optional ack on the last accepted sample.
    task automatic drive(input int n, input int kind, input bit alt, input bit ack_last, output int cyc);
        int k;
        bit ce;
        k = 0; ce = 1'b1; cyc = 0;
        while (k < n) begin
            ce = alt ? !ce : 1'b1;
            clken = ce;
            bus.sample_valid = 1'b1;
            bus.sample_i = wave(kind, k);
            if (ack_last) bus.result_ack_i = ce && (k == n - 1);
            @(posedge clk); #1;
            cyc++;
            if (ce) k++;
        end
        bus.sample_valid = 1'b0;
        clken = 1'b1;
        if (ack_last) bus.result_ack_i = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Result consumer: holds ack while a result is pending
    always @(negedge clk) begin
        if (auto_ack) bus.result_ack_i = bus.result_valid_o;
    end

    // Monitor: each fresh result is compared against the oldest expectation
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (bus.result_valid_o && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_zc_count", 64'(bus.zc_count_o), 64'(e.zc));
                    chk("mon_phi_inc", 64'(bus.phi_inc_est_o), 64'(e.phi));
                    chk("mon_span", 64'(bus.span_o), 64'(e.span));
                end
            end
            prev_v = bus.result_valid_o;
        end
    end

    initial begin
        exp_p.zc = 11'd128; exp_p.phi = 30'h0800_0000; exp_p.span = 10'(SPAN_P);
        exp_z.zc = '0;      exp_z.phi = '0;            exp_z.span = '0;
        reset = 1'b1; clken = 1'b1;
        bus.run = 1'b0; bus.sample_valid = 1'b0; bus.sample_i = '0; bus.result_ack_i = 1'b0;

        step(3);
        chk("rst_busy", 64'(bus.busy_o), 0);
        chk("rst_valid", 64'(bus.result_valid_o), 0);
        chk("rst_overrun", 64'(bus.overrun_o), 0);
        chk("rst_zc", 64'(bus.zc_count_o), 0);
        chk("rst_phi", 64'(bus.phi_inc_est_o), 0);
        chk("rst_span", 64'(bus.span_o), 0);
        reset = 1'b0;
        step(1);

        // Periodic wave, no ack: first result, then overrun on the second window
        bus.run = 1'b1;
        step(1);
        chk("busy_after_run", 64'(bus.busy_o), 1);
        exp_q.push_back(exp_p);
        drive(1024, 0, 1'b0, 1'b0, ncyc);
        chk("win1_valid", 64'(bus.result_valid_o), 1);
        chk("win1_overrun", 64'(bus.overrun_o), 0);
        drive(1024, 0, 1'b0, 1'b0, ncyc);
        chk("win2_overrun", 64'(bus.overrun_o), 1);
        chk("win2_zc", 64'(bus.zc_count_o), 128);

        bus.run = 1'b0;
        step(1);
        chk("stop_busy", 64'(bus.busy_o), 0);
        chk("stop_overrun_clr", 64'(bus.overrun_o), 0);
        chk("stop_valid_held", 64'(bus.result_valid_o), 1);

        // Ack coinciding with the load keeps valid and raises no overrun
        bus.run = 1'b1;
        step(1);
        drive(1024, 0, 1'b0, 1'b1, ncyc);
        chk("ackload_valid", 64'(bus.result_valid_o), 1);
        chk("ackload_overrun", 64'(bus.overrun_o), 0);
        step(1);
        chk("ackload_valid_hold", 64'(bus.result_valid_o), 1);
        auto_ack = 1'b1;
        step(3);
        chk("ack_clears_valid", 64'(bus.result_valid_o), 0);

        // Abort mid-window: no result, held outputs unchanged
        drive(500, 0, 1'b0, 1'b0, ncyc);
        bus.run = 1'b0;
        step(1);
        chk("abort_busy", 64'(bus.busy_o), 0);
        step(5);
        chk("abort_no_valid", 64'(bus.result_valid_o), 0);
        chk("abort_zc_held", 64'(bus.zc_count_o), 128);
        chk("abort_phi_held", 64'(bus.phi_inc_est_o), 64'h0800_0000);

        // Small alternating samples stay inside the hysteresis band
        bus.run = 1'b1;
        step(1);
        exp_q.push_back(exp_z);
        drive(1024, 1, 1'b0, 1'b0, ncyc);
        chk("hyst_valid", 64'(bus.result_valid_o), 1);
        step(4);

        // clken on alternate cycles
        bus.run = 1'b0;
        step(1);
        bus.run = 1'b1;
        step(1);
        exp_q.push_back(exp_p);
        drive(1024, 0, 1'b1, 1'b0, ncyc);
        chk("clken_cycles", 64'(ncyc), 2048);
        chk("clken_valid", 64'(bus.result_valid_o), 1);
        step(4);

        // Reset mid-window, then a clean window with run held high
        drive(700, 0, 1'b0, 1'b0, ncyc);
        reset = 1'b1;
        #1;
        chk("midrst_zc", 64'(bus.zc_count_o), 0);
        chk("midrst_phi", 64'(bus.phi_inc_est_o), 0);
        chk("midrst_span", 64'(bus.span_o), 0);
        chk("midrst_busy", 64'(bus.busy_o), 0);
        chk("midrst_valid", 64'(bus.result_valid_o), 0);
        chk("midrst_overrun", 64'(bus.overrun_o), 0);
        step(1);
        reset = 1'b0;
        step(1);
        chk("postrst_busy", 64'(bus.busy_o), 1);
        exp_q.push_back(exp_p);
        drive(1024, 0, 1'b0, 1'b0, ncyc);
        chk("postrst_valid", 64'(bus.result_valid_o), 1);
        step(4);

        chk("results_outstanding", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
